mem_bus_master: RTL and testbench

- Initiator side of the shared single-port memory bus used by the SimpleCISC core. The bus has a bidirectional 16-bit data line, a 16-bit address, and a write strobe.
- Accepts one request at a time from the CPU control path over a valid/ready handshake.
- Sequences address setup, the write strobe, and tristate data drive/release.
- Returns read data or a write completion as a single-cycle response pulse.
- Sits between the datapath and the memory model/macro, and is the only driver of the bus from the CPU side.

---
 rtl/mem_bus_master.sv | 144 ++++++++++++++
 tb/tb_mem_bus_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Initiator for the shared single-port memory bus: one request at a time, sequenced strobe and tristate data.
// Optional MEM_BUS_STATS_EN adds read/write/error completion counters.
module mem_bus_master #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_DEPTH   = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] address,
    output logic              write,
`ifdef MEM_BUS_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [7:0]        err_count,
`endif
    inout  wire  [DATA_W-1:0] data
);

    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W    = $clog2(WAIT_EFF + 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            address_q <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            address_q <= address_d;
            write_q   <= write_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        address_d = address_q;
        write_d   = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    wdata_d = req_wdata;
                    // Out-of-range requests skip the bus entirely, leaving address untouched.
                    if (32'(req_addr) >= 32'(MEM_DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d     = 1'b0;
                        address_d = req_addr;
                        state_d   = SETUP;
                    end
                end
            end
            SETUP: begin
                if (wr_q) begin
                    write_d = 1'b1;
                    state_d = ACCESS;
                end else begin
                    wcnt_d  = CNT_W'(WAIT_EFF - 1);
                    state_d = WAIT;
                end
            end
            ACCESS: state_d = HOLD;
            HOLD:   state_d = RESP;
            WAIT: begin
                if (wcnt_q == '0) begin
                    rdata_d = data;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Drive is decoded from the state register so reset releases the bus immediately.
    assign data      = (state_q == ACCESS || state_q == HOLD) ? wdata_q : 'z;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;
    assign address   = address_q;
    assign write     = write_q;

`ifdef MEM_BUS_STATS_EN
    logic [15:0] rd_count_q, wr_count_q;
    logic [7:0]  err_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else if (state_q == RESP) begin
            if (err_q)     err_count_q <= err_count_q + 8'd1;
            else if (wr_q) wr_count_q  <= wr_count_q + 16'd1;
            else           rd_count_q  <= rd_count_q + 16'd1;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: bus memory model plus a transaction-level reference (latency, data, error rules).
module tb_mem_bus_master;
    localparam int WAIT_CYCLES = 1;
    localparam int WEFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int DEPTH = 512;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic [15:0] address;
    logic        write;
    wire  [15:0] data;
`ifdef MEM_BUS_STATS_EN
    logic [15:0] rd_count, wr_count;
    logic [7:0]  err_count;
`endif

    mem_bus_master #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .address(address), .write(write),
`ifdef MEM_BUS_STATS_EN
        .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count),
`endif
        .data(data)
    );

    always #5 clock = ~clock;

    // Memory: captures on the strobe edge, drives read data except while the strobe or hold phase is active.
    logic [15:0] mem [0:DEPTH-1];
    logic        wr_d1 = 1'b0;
    always @(posedge clock) begin
        wr_d1 <= write;
        if (write) mem[address[8:0]] <= data;
    end
    assign data = (!write && !wr_d1) ? mem[address[8:0]] : 'z;

    // Reference model state
    logic [15:0] exp_mem [0:DEPTH-1];
    logic [15:0] last_rd;
    logic [15:0] last_addr;
    int n_chk = 0, n_err = 0;

    // Observations of the most recent transaction
    int          o_wait, o_lat, o_wp;
    logic [15:0] o_saddr, o_rdata;
    logic        o_dok, o_err, o_rdrop;

    // Caller must be at a falling edge; returns at the falling edge where rsp_valid is seen (req_valid left high).
    task automatic run_txn(input logic wr, input logic [15:0] a, input logic [15:0] wd);
        logic prev;
        req_write = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        o_wait = 0;
        while (!req_ready && o_wait < 50) begin
            @(negedge clock);
            o_wait++;
        end
        @(posedge clock);
        #1 o_rdrop = !req_ready;
        o_lat = -1; o_wp = 0; o_dok = 1'b1; prev = 1'b0;
        o_saddr = '0; o_rdata = '0; o_err = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) o_saddr = address;
            if (write) begin
                o_wp++;
                if (prev || data !== wd) o_dok = 1'b0;
            end
            if (prev && data !== wd) o_dok = 1'b0;
            prev = write;
            if (rsp_valid) begin
                o_lat = c; o_rdata = rsp_rdata; o_err = rsp_error;
                break;
            end
        end
    endtask

    // Model update for a completed transaction; returns expected values through globals
    int          e_lat, e_wp;
    logic [15:0] e_rdata, e_saddr;
    logic        e_err;
    task automatic model(input logic wr, input logic [15:0] a, input logic [15:0] wd);
        e_err = (a >= 16'(DEPTH));
        e_lat = e_err ? 1 : (wr ? 4 : 2 + WEFF);
        e_wp  = (!e_err && wr) ? 1 : 0;
        if (!e_err) last_addr = a;
        e_saddr = last_addr;
        if (!e_err && wr) exp_mem[a[8:0]] = wd;
        if (!e_err && !wr) last_rd = exp_mem[a[8:0]];
        e_rdata = last_rd;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        last_rd = '0; last_addr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_error !== 1'b0 ||
            address !== 16'h0 || write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b addr=%h wr=%b expected 1 0 0000 0 0000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_error, address, write);
        end
        @(negedge clock);
        reset = 1'b0;
        last_rd = '0; last_addr = '0;
    endtask

    task automatic test_read();
        run_txn(1'b0, 16'd150, 16'h0); req_valid = 1'b0;
        model(1'b0, 16'd150, 16'h0);
        n_chk++;
        if (o_lat !== e_lat || o_rdata !== 16'h0007 || o_err !== 1'b0) begin
            n_err++;
            $display("FAIL read150: lat=%0d rdata=%h err=%b expected lat=%0d rdata=0007 err=0", o_lat, o_rdata, o_err, e_lat);
        end
        n_chk++;
        if (o_saddr !== 16'd150 || o_wp !== 0 || o_rdrop !== 1'b1) begin
            n_err++;
            $display("FAIL read150_bus: setup_addr=%0d wpulses=%0d ready_drop=%b expected 150 0 1", o_saddr, o_wp, o_rdrop);
        end
    endtask

    task automatic test_write_read();
        run_txn(1'b1, 16'd151, 16'h1234); req_valid = 1'b0;
        model(1'b1, 16'd151, 16'h1234);
        n_chk++;
        if (o_lat !== 4 || o_wp !== 1 || o_dok !== 1'b1 || o_err !== 1'b0 || o_saddr !== 16'd151) begin
            n_err++;
            $display("FAIL write151: lat=%0d wpulses=%0d data_ok=%b err=%b setup_addr=%0d expected 4 1 1 0 151",
                     o_lat, o_wp, o_dok, o_err, o_saddr);
        end
        n_chk++;
        if (o_rdata !== e_rdata) begin
            n_err++;
            $display("FAIL write151_rdata_hold: rdata=%h expected %h", o_rdata, e_rdata);
        end
        run_txn(1'b0, 16'd151, 16'h0); req_valid = 1'b0;
        model(1'b0, 16'd151, 16'h0);
        n_chk++;
        if (o_lat !== e_lat || o_rdata !== 16'h1234 || o_err !== 1'b0) begin
            n_err++;
            $display("FAIL read151: lat=%0d rdata=%h err=%b expected %0d 1234 0", o_lat, o_rdata, o_err, e_lat);
        end
    endtask

    task automatic test_out_of_range();
        run_txn(1'b0, 16'd600, 16'h0); req_valid = 1'b0;
        model(1'b0, 16'd600, 16'h0);
        n_chk++;
        if (o_lat !== 1 || o_err !== 1'b1) begin
            n_err++;
            $display("FAIL oor: lat=%0d err=%b expected 1 1", o_lat, o_err);
        end
        n_chk++;
        if (o_saddr !== e_saddr || o_wp !== 0 || o_rdata !== e_rdata) begin
            n_err++;
            $display("FAIL oor_bus: addr=%0d wpulses=%0d rdata=%h expected %0d 0 %h", o_saddr, o_wp, o_rdata, e_saddr, e_rdata);
        end
        run_txn(1'b1, 16'd512, 16'h5555); req_valid = 1'b0;
        model(1'b1, 16'd512, 16'h5555);
        n_chk++;
        if (o_lat !== 1 || o_err !== 1'b1 || o_wp !== 0) begin
            n_err++;
            $display("FAIL oor_write512: lat=%0d err=%b wpulses=%0d expected 1 1 0", o_lat, o_err, o_wp);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 16'd10, 16'h00AA);
        model(1'b1, 16'd10, 16'h00AA);
        n_chk++;
        if (o_lat !== 4 || o_wp !== 1 || o_dok !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_write: lat=%0d wpulses=%0d data_ok=%b expected 4 1 1", o_lat, o_wp, o_dok);
        end
        run_txn(1'b0, 16'd10, 16'h0); req_valid = 1'b0;
        model(1'b0, 16'd10, 16'h0);
        n_chk++;
        if (o_wait !== 1 || o_lat !== e_lat || o_rdata !== 16'h00AA) begin
            n_err++;
            $display("FAIL b2b_read: wait=%0d lat=%0d rdata=%h expected 1 %0d 00aa", o_wait, o_lat, o_rdata, e_lat);
        end
    endtask

    task automatic test_random();
        logic        wr;
        logic [15:0] a, wd;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(DEPTH, 65535)) : 16'($urandom_range(0, DEPTH - 1));
            if (a == 16'd150 || a == 16'd200) a = 16'd149;
            wd = 16'($urandom);
            run_txn(wr, a, wd);
            if ($urandom_range(0, 1) == 0) req_valid = 1'b0;
            model(wr, a, wd);
            n_chk++;
            if (o_lat !== e_lat || o_err !== e_err || o_rdata !== e_rdata || o_wp !== e_wp ||
                o_saddr !== e_saddr || (wr && !e_err && o_dok !== 1'b1)) begin
                n_err++;
                $display("FAIL random[%0d] wr=%b a=%0d: lat=%0d err=%b rdata=%h wp=%0d addr=%0d dok=%b expected %0d %b %h %0d %0d",
                         i, wr, a, o_lat, o_err, o_rdata, o_wp, o_saddr, o_dok, e_lat, e_err, e_rdata, e_wp, e_saddr);
            end
        end
        req_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_write();
        int  guard;
        logic seen;
        req_write = 1'b1; req_addr = 16'd200; req_wdata = 16'hBEEF; req_valid = 1'b1;
        guard = 0;
        while (write !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        req_valid = 1'b0;
        n_chk++;
        if (write !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_reach_access: write=%b expected 1", write);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (write !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || address !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_async: write=%b valid=%b ready=%b addr=%h expected 0 0 1 0000",
                     write, rsp_valid, req_ready, address);
        end
        @(negedge clock);
        reset = 1'b0;
        last_rd = '0; last_addr = '0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (rsp_valid) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_drop: rsp_seen=%b ready=%b expected 0 1", seen, req_ready);
        end
        run_txn(1'b0, 16'd150, 16'h0); req_valid = 1'b0;
        model(1'b0, 16'd150, 16'h0);
        n_chk++;
        if (o_lat !== e_lat || o_rdata !== 16'h0007 || o_err !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_read150: lat=%0d rdata=%h err=%b expected %0d 0007 0", o_lat, o_rdata, o_err, e_lat);
        end
    endtask

    task automatic test_stats();
`ifdef MEM_BUS_STATS_EN
        apply_reset();
        run_txn(1'b0, 16'd1, 16'h0);      model(1'b0, 16'd1, 16'h0);
        run_txn(1'b1, 16'd2, 16'h0102);   model(1'b1, 16'd2, 16'h0102);
        run_txn(1'b0, 16'd3, 16'h0);      model(1'b0, 16'd3, 16'h0);
        run_txn(1'b0, 16'd700, 16'h0);    model(1'b0, 16'd700, 16'h0);
        run_txn(1'b1, 16'd4, 16'h0104);   model(1'b1, 16'd4, 16'h0104);
        run_txn(1'b0, 16'd2, 16'h0);      model(1'b0, 16'd2, 16'h0);
        req_valid = 1'b0;
        @(negedge clock);
        n_chk++;
        if (rd_count !== 16'd3 || wr_count !== 16'd2 || err_count !== 8'd1) begin
            n_err++;
            $display("FAIL stats_count: rd=%0d wr=%0d err=%0d expected 3 2 1", rd_count, wr_count, err_count);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0 || err_count !== 8'd0) begin
            n_err++;
            $display("FAIL stats_reset: rd=%0d wr=%0d err=%0d expected 0 0 0", rd_count, wr_count, err_count);
        end
        @(negedge clock);
        reset = 1'b0;
        last_rd = '0; last_addr = '0;
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 16'(i * 3 + 1);
            exp_mem[i] = 16'(i * 3 + 1);
        end
        mem[150] = 16'h0007;
        exp_mem[150] = 16'h0007;
        last_rd = '0; last_addr = '0;
        @(negedge clock);
        test_reset();
        test_read();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        test_stats();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
